// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the LEGv8 core.
// Keeps the PC, issues one fetch at a time to instruction memory, and holds
// the fetched instruction in IF/ID. A skid buffer catches a response that
// lands while ID is stalled. A taken branch redirects the PC and flushes IF/ID.
// A response to a fetch that a branch made stale is absorbed in DROP.

module if_stage #(
    parameter int unsigned          INST_SIZE = 32,
    parameter int unsigned          ADDR_SIZE = 64,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [ADDR_SIZE-1:0] br_target,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [INST_SIZE-1:0] imem_rdata,
    output logic                 if_id_valid,
    output logic [ADDR_SIZE-1:0] if_id_pc,
    output logic [INST_SIZE-1:0] if_id_inst,
    output logic [10:0]          opcode
);

    // IDLE : one dead cycle after reset before the first fetch
    // ISSUE: request on the bus this cycle
    // WAIT : live request outstanding
    // HOLD : response parked in the skid buffer until the stall clears
    // DROP : request outstanding whose response must be thrown away
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DROP
    } fetchStateT;

    fetchStateT             state, stateNext;
    logic [ADDR_SIZE-1:0]   pcReg, pcNext;
    logic [INST_SIZE-1:0]   skidBuf, skidNext;
    logic                   ifIdValid, ifIdValidNext;
    logic [ADDR_SIZE-1:0]   ifIdPc, ifIdPcNext;
    logic [INST_SIZE-1:0]   ifIdInst, ifIdInstNext;

    logic [ADDR_SIZE-1:0]   brPc;
    logic [ADDR_SIZE-1:0]   pcPlus4;

    // Branch targets are word aligned by clearing the two low bits.
    assign brPc    = br_target & ~ADDR_SIZE'(3);
    // The increment wraps naturally modulo 2^ADDR_SIZE.
    assign pcPlus4 = pcReg + ADDR_SIZE'(4);

    // Next-state, next-PC and IF/ID load decisions; redirect outranks stall.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statements leaves it unassigned and infers a latch.
        stateNext     = state;
        pcNext        = pcReg;
        skidNext      = skidBuf;
        ifIdValidNext = ifIdValid;
        ifIdPcNext    = ifIdPc;
        ifIdInstNext  = ifIdInst;

        if (br_taken) begin
            ifIdValidNext = 1'b0;
            pcNext        = brPc;
            skidNext      = '0;
            unique case (state)
                IDLE:    stateNext = ISSUE;
                ISSUE:   stateNext = DROP;
                WAIT:    stateNext = imem_rvalid ? ISSUE : DROP;
                HOLD:    stateNext = ISSUE;
                DROP:    stateNext = imem_rvalid ? ISSUE : DROP;
                default: stateNext = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    stateNext = ISSUE;
                end
                ISSUE: begin
                    stateNext = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            skidNext  = imem_rdata;
                            stateNext = HOLD;
                        end else begin
                            ifIdValidNext = 1'b1;
                            ifIdPcNext    = pcReg;
                            ifIdInstNext  = imem_rdata;
                            pcNext        = pcPlus4;
                            stateNext     = ISSUE;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifIdValidNext = 1'b1;
                        ifIdPcNext    = pcReg;
                        ifIdInstNext  = skidBuf;
                        pcNext        = pcPlus4;
                        stateNext     = ISSUE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        stateNext = ISSUE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // State, PC, skid buffer and IF/ID register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pcReg     <= RESET_PC;
            // NOTE: the skid buffer and IF/ID data fields are plain flops, not
            // a memory array, so resetting them costs nothing and keeps the
            // opcode output at a known value straight out of reset.
            skidBuf   <= '0;
            ifIdValid <= 1'b0;
            ifIdPc    <= '0;
            ifIdInst  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            state     <= stateNext;
            pcReg     <= pcNext;
            skidBuf   <= skidNext;
            ifIdValid <= ifIdValidNext;
            ifIdPc    <= ifIdPcNext;
            ifIdInst  <= ifIdInstNext;
        end
    end

    // Memory request is decoded from state alone; the address is the PC flop.
    assign imem_req    = (state == ISSUE);
    assign imem_addr   = (state == ISSUE) ? pcReg : '0;

    assign if_id_valid = ifIdValid;
    assign if_id_pc    = ifIdPc;
    assign if_id_inst  = ifIdInst;
    assign opcode      = ifIdInst[31:21];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps for reset, the basic fetch flow, stall,
// redirect, PC wrap and mid-fetch reset, followed by a randomised run. The
// reference model tracks fetches as transactions: the expected next fetch
// address, one outstanding fetch that a redirect can make stale, an optional
// parked response, and the expected IF/ID contents.

module tb_if_stage;

    localparam int INST_SIZE = 32;
    localparam int ADDR_SIZE = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 stall = 1'b0;
    logic                 br_taken = 1'b0;
    logic [ADDR_SIZE-1:0] br_target = '0;
    logic                 imem_req;
    logic [ADDR_SIZE-1:0] imem_addr;
    logic                 imem_rvalid = 1'b0;
    logic [INST_SIZE-1:0] imem_rdata = '0;
    logic                 if_id_valid;
    logic [ADDR_SIZE-1:0] if_id_pc;
    logic [INST_SIZE-1:0] if_id_inst;
    logic [10:0]          opcode;

    if_stage #(
        .INST_SIZE(INST_SIZE),
        .ADDR_SIZE(ADDR_SIZE),
        .RESET_PC (64'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_id_valid(if_id_valid),
        .if_id_pc   (if_id_pc),
        .if_id_inst (if_id_inst),
        .opcode     (opcode)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Memory device: answers each request after 'latency' cycles.
    int          latency = 1;
    logic        memBusy = 1'b0;
    int          memCnt = 0;
    logic [63:0] memAddr = '0;
    int          reqCount = 0;

    // Reference model.
    logic        mValid;
    logic [63:0] mPc;
    logic [31:0] mInst;
    logic [63:0] mFetchPc;
    logic        outstanding;
    logic        stale;
    logic [63:0] pendAddr;
    logic        buffered;
    logic [63:0] bufPc;

    function automatic logic [31:0] memData(input logic [63:0] a);
        case (a)
            64'h0:                   return 32'hF844_02C9;
            64'h4:                   return 32'h8B09_026A;
            64'h8:                   return 32'hCB0A_028B;
            64'hC:                   return 32'hB4FF_FF6B;
            64'hFFFF_FFFF_FFFF_FFFC: return 32'h1400_0040;
            default:                 return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A5A_1234;
        endcase
    endfunction

    function automatic void resetModel();
        mValid      = 1'b0;
        mPc         = '0;
        mInst       = '0;
        mFetchPc    = 64'h0;
        outstanding = 1'b0;
        stale       = 1'b0;
        pendAddr    = '0;
        buffered    = 1'b0;
        bufPc       = '0;
    endfunction

    function automatic void commitModel(input logic [63:0] a);
        mValid   = 1'b1;
        mPc      = a;
        mInst    = memData(a);
        mFetchPc = a + 64'd4;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount += 1;
        assert (obs === exp) passCount += 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_req"},   {63'b0, imem_req},    64'd0);
        check({tag, "_addr"},  imem_addr,            64'd0);
        check({tag, "_valid"}, {63'b0, if_id_valid}, 64'd0);
        check({tag, "_pc"},    if_id_pc,             64'd0);
        check({tag, "_inst"},  {32'b0, if_id_inst},  64'd0);
        check({tag, "_opc"},   {53'b0, opcode},      64'd0);
    endtask

    task automatic checkReq(input string tag, input logic [63:0] addr);
        check({tag, "_req"},  {63'b0, imem_req}, 64'd1);
        check({tag, "_addr"}, imem_addr,         addr);
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic tick(input logic st, input logic br, input logic [63:0] tgt);
        logic resp;
        resp        = 1'b0;
        imem_rvalid = 1'b0;
        if (memBusy) begin
            memCnt -= 1;
            if (memCnt == 0) begin
                memBusy     = 1'b0;
                resp        = 1'b1;
                imem_rvalid = 1'b1;
                imem_rdata  = memData(memAddr);
            end
        end
        stall     = st;
        br_taken  = br;
        br_target = tgt;

        if (imem_req) begin
            check("req_single", {62'b0, outstanding, buffered}, 64'd0);
            check("req_addr", imem_addr, mFetchPc);
            memBusy     = 1'b1;
            memCnt      = latency;
            memAddr     = imem_addr;
            reqCount   += 1;
            outstanding = 1'b1;
            stale       = 1'b0;
            pendAddr    = mFetchPc;
        end else begin
            check("addr_idle", imem_addr, 64'd0);
        end

        if (br) begin
            mValid   = 1'b0;
            buffered = 1'b0;
            mFetchPc = tgt & ~64'd3;
            if (outstanding) begin
                if (resp) outstanding = 1'b0;
                else      stale = 1'b1;
            end
        end else if (resp && outstanding) begin
            outstanding = 1'b0;
            if (!stale) begin
                if (st) begin
                    buffered = 1'b1;
                    bufPc    = pendAddr;
                end else begin
                    commitModel(pendAddr);
                end
            end
        end else if (buffered && !st) begin
            buffered = 1'b0;
            commitModel(bufPc);
        end

        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;

        check("ifid_valid", {63'b0, if_id_valid}, {63'b0, mValid});
        if (mValid) begin
            check("ifid_pc",   if_id_pc,            mPc);
            check("ifid_inst", {32'b0, if_id_inst}, {32'b0, mInst});
            check("opcode",    {53'b0, opcode},     {53'b0, mInst[31:21]});
        end
    endtask

    initial begin
        int reqBase;
        logic st;
        logic br;
        logic [63:0] tgt;

        resetModel();

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("rst");
        rst_n = 1'b1;

        // 1: first two fetches with 1-cycle memory.
        latency = 1;
        tick(1'b0, 1'b0, '0);
        checkReq("t1_first", 64'h0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("t1_inst0",  {32'b0, if_id_inst},  64'hF844_02C9);
        check("t1_pc0",    if_id_pc,             64'h0);
        check("t1_opcode", {53'b0, opcode},      64'h7C2);
        check("t1_valid",  {63'b0, if_id_valid}, 64'd1);
        checkReq("t1_second", 64'h4);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("t1_inst1", {32'b0, if_id_inst}, 64'h8B09_026A);
        check("t1_pc1",   if_id_pc,            64'h4);
        checkReq("t1_third", 64'h8);

        // 2: stall for three cycles while the addr-8 response lands.
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("t2_hold_inst", {32'b0, if_id_inst}, 64'h8B09_026A);
        check("t2_noreq_a",   {63'b0, imem_req},   64'd0);
        tick(1'b1, 1'b0, '0);
        check("t2_hold_pc",   if_id_pc,            64'h4);
        check("t2_noreq_b",   {63'b0, imem_req},   64'd0);
        tick(1'b0, 1'b0, '0);
        check("t2_inst", {32'b0, if_id_inst}, 64'hCB0A_028B);
        check("t2_pc",   if_id_pc,            64'h8);
        checkReq("t2_next", 64'hC);

        // 3: redirect while waiting on a 3-cycle fetch.
        latency = 3;
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 64'h103);
        check("t3_flush", {63'b0, if_id_valid}, 64'd0);
        check("t3_noreq", {63'b0, imem_req},    64'd0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("t3_stale_dropped", {63'b0, if_id_valid}, 64'd0);
        checkReq("t3_target", 64'h100);

        // 4: redirect coincident with stall while a response is parked.
        latency = 1;
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("t4_parked_noreq", {63'b0, imem_req}, 64'd0);
        tick(1'b1, 1'b1, 64'h200);
        check("t4_flush", {63'b0, if_id_valid}, 64'd0);
        checkReq("t4_target", 64'h200);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("t4_pc",   if_id_pc,            64'h200);
        check("t4_inst", {32'b0, if_id_inst}, {32'b0, memData(64'h200)});

        // 5: fetch at the top of the address space, then wrap to zero.
        tick(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t5_flush", {63'b0, if_id_valid}, 64'd0);
        tick(1'b0, 1'b0, '0);
        checkReq("t5_top", 64'hFFFF_FFFF_FFFF_FFFC);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("t5_pc",   if_id_pc,            64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_inst", {32'b0, if_id_inst}, 64'h1400_0040);
        checkReq("t5_wrap", 64'h0);

        // 6: reset in the middle of a fetch; the late response must be ignored.
        latency = 3;
        tick(1'b0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1 checkReset("t6_async");
        resetModel();
        @(negedge clk);
        memBusy = 1'b1;
        memCnt  = 1;
        rst_n   = 1'b1;
        latency = 1;
        tick(1'b0, 1'b0, '0);
        check("t6_stale_ignored", {63'b0, if_id_valid}, 64'd0);
        checkReq("t6_restart", 64'h0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("t6_inst", {32'b0, if_id_inst}, 64'hF844_02C9);

        // Randomised run: stalls, redirects and 1..3 cycle memory latency.
        reqBase = reqCount;
        for (int i = 0; i < 3000; i++) begin
            latency = int'($urandom_range(1, 3));
            st      = ($urandom_range(0, 2) == 0);
            br      = ($urandom_range(0, 19) == 0);
            tgt     = {$urandom, $urandom};
            tick(st, br, tgt);
        end
        check("rand_progress", {63'b0, (reqCount - reqBase) >= 200}, 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
